// File: rtl/resp_uart_tx.sv
// Response serializer: frames fixed-format reply messages onto an 8N1 UART line.
// Optional macro RESP_CRC_EN replaces the zero trailer with a CRC-32 of the message body.
module resp_uart_tx #(
  parameter int baud_rate    = 1,
  parameter int sys_clk_freq = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_nonce,
  output logic        TX,
  output logic        busy
);

  localparam int BP    = sys_clk_freq / baud_rate;
  localparam int CNT_W = (BP > 1) ? $clog2(BP) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BP - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {M_PONG, M_INFO, M_INVALID, M_NONCE} msg_t;

  state_t           state, state_nxt;
  msg_t             msg, msg_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [3:0]       byte_idx, byte_nxt;
  logic [31:0]      nonce, nonce_nxt;
  logic             tx_q, tx_nxt;
  logic             ready_q, ready_nxt;
  logic             busy_q, busy_nxt;
  logic [31:0]      trailer;
  logic [7:0]       cur_byte;
  logic [3:0]       last_idx;
  logic [2:0]       bit_inc;

  // Reserved request codes fall back to the INVALID reply.
  function automatic msg_t to_msg(input logic [2:0] t);
    case (t)
      3'd0:    return M_PONG;
      3'd1:    return M_INFO;
      3'd3:    return M_NONCE;
      default: return M_INVALID;
    endcase
  endfunction

  function automatic logic [3:0] msg_last(input msg_t m);
    case (m)
      M_PONG:  return 4'd0;
      M_INFO:  return 4'd15;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input msg_t m, input logic [3:0] idx,
                                          input logic [31:0] n, input logic [31:0] t);
    logic [7:0] b;
    b = 8'h00;
    case (m)
      M_PONG: b = 8'h01;
      M_INFO: begin
        case (idx)
          4'd0:  b = 8'h10;
          4'd4:  b = 8'hDE;
          4'd5:  b = 8'hAD;
          4'd6:  b = 8'hBE;
          4'd7:  b = 8'hEF;
          4'd8:  b = 8'h13;
          4'd9:  b = 8'h37;
          4'd10: b = 8'h0D;
          4'd11: b = 8'h13;
          4'd12: b = t[7:0];
          4'd13: b = t[15:8];
          4'd14: b = t[23:16];
          4'd15: b = t[31:24];
          default: b = 8'h00;
        endcase
      end
      M_INVALID: begin
        case (idx[2:0])
          3'd0: b = 8'h08;
          3'd3: b = 8'h01;
          3'd4: b = t[7:0];
          3'd5: b = t[15:8];
          3'd6: b = t[23:16];
          3'd7: b = t[31:24];
          default: b = 8'h00;
        endcase
      end
      default: begin
        case (idx[2:0])
          3'd0: b = 8'h08;
          3'd3: b = 8'h03;
          3'd4: b = n[31:24];
          3'd5: b = n[23:16];
          3'd6: b = n[15:8];
          3'd7: b = n[7:0];
          default: b = 8'h00;
        endcase
      end
    endcase
    return b;
  endfunction

`ifdef RESP_CRC_EN
  logic [31:0] crc, crc_nxt;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign trailer = ~crc;
`else
  assign trailer = 32'h0;
`endif

  assign last_idx  = msg_last(msg);
  assign cur_byte  = msg_byte(msg, byte_idx, nonce, trailer);
  assign bit_inc   = bit_idx + 3'd1;
  assign TX        = tx_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;

  always_comb begin
    state_nxt = state;
    msg_nxt   = msg;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    nonce_nxt = nonce;
    tx_nxt    = tx_q;
    ready_nxt = ready_q;
    busy_nxt  = busy_q;
`ifdef RESP_CRC_EN
    crc_nxt   = crc;
`endif
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        tx_nxt    = 1'b1;
        if (req_valid && ready_q) begin
          state_nxt = START;
          msg_nxt   = to_msg(req_type);
          nonce_nxt = req_nonce;
          cnt_nxt   = '0;
          bit_nxt   = 3'd0;
          byte_nxt  = 4'd0;
          tx_nxt    = 1'b0;
          ready_nxt = 1'b0;
          busy_nxt  = 1'b1;
`ifdef RESP_CRC_EN
          crc_nxt   = 32'hFFFFFFFF;
`endif
        end
      end
      START: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = '0;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
          tx_nxt    = cur_byte[0];
`ifdef RESP_CRC_EN
          // Fold body bytes only; trailer bytes read the frozen result.
          if (({1'b0, byte_idx} + 5'd4) <= {1'b0, last_idx})
            crc_nxt = crc32_byte(crc, cur_byte);
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_inc;
            tx_nxt  = cur_byte[bit_inc];
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (byte_idx == last_idx) begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            byte_nxt  = byte_idx + 4'd1;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      msg      <= M_PONG;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      nonce    <= 32'h0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef RESP_CRC_EN
      crc      <= 32'h0;
`endif
    end else begin
      state    <= state_nxt;
      msg      <= msg_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      nonce    <= nonce_nxt;
      tx_q     <= tx_nxt;
      ready_q  <= ready_nxt;
      busy_q   <= busy_nxt;
`ifdef RESP_CRC_EN
      crc      <= crc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_resp_uart_tx.sv
// Bench for resp_uart_tx: directed and random replies decoded off the serial line
// and compared with byte lists built from the message definitions.
module tb_resp_uart_tx;

  localparam int BR  = 1;
  localparam int SCF = 16;
  localparam int BP  = SCF / BR;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_nonce = 32'h0;
  logic        TX;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  resp_uart_tx #(.baud_rate(BR), .sys_clk_freq(SCF)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_nonce(req_nonce), .TX(TX), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference CRC-32, one bit at a time over the whole byte list.
  function automatic logic [31:0] ref_crc(input logic [7:0] bytes[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (bytes[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ bytes[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  task automatic build_exp(input int t, input logic [31:0] n);
    logic [31:0] tr;
    exp_q.delete();
    if (t == 0) begin
      exp_q = '{8'h01};
      return;
    end
    if (t == 1)
      exp_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h13, 8'h37, 8'h0D, 8'h13};
    else if (t == 3)
      exp_q = '{8'h08, 8'h00, 8'h00, 8'h03, n[31:24], n[23:16], n[15:8], n[7:0]};
    else
      exp_q = '{8'h08, 8'h00, 8'h00, 8'h01};
    if (t != 3) begin
`ifdef RESP_CRC_EN
      tr = ref_crc(exp_q);
`else
      tr = 32'h0;
`endif
      for (int i = 0; i < 4; i++) exp_q.push_back(tr[8*i +: 8]);
    end
  endtask

  // Raise a request and return at #1 after the accepting edge.
  task automatic start_req(input int t, input logic [31:0] n);
    int waited;
    req_type  = 3'(t);
    req_nonce = n;
    req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin
      @(posedge CLK); #1;
      waited++;
    end
    if (req_ready !== 1'b1) check("accept_timeout", {31'h0, req_ready}, 32'h1);
    @(posedge CLK); #1;
    check("accept_busy", {31'h0, busy}, 32'h1);
    check("accept_ready", {31'h0, req_ready}, 32'h0);
    check("accept_start", {31'h0, TX}, 32'h0);
  endtask

  task automatic recv_msg(input int pulse_at, input bit hold);
    int c;
    logic [9:0] frame;
    bit stable;
    bit busy_ok;
    busy_ok = 1'b1;
    for (int b = 0; b < exp_q.size(); b++) begin
      frame  = '0;
      stable = 1'b1;
      for (int j = 0; j < 10; j++) begin
        for (int k = 0; k < BP; k++) begin
          c = (b * 10 + j) * BP + k;
          if (c == 0 && !hold) begin
            req_valid = 1'b0;
            req_type  = 3'($urandom);
            req_nonce = $urandom;
          end
          if (pulse_at > 0 && c == pulse_at) req_valid = 1'b1;
          if (pulse_at > 0 && c == pulse_at + 1) req_valid = 1'b0;
          if (k == 0) frame[j] = TX;
          else if (TX !== frame[j]) stable = 1'b0;
          if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 1'b0;
          @(posedge CLK); #1;
        end
      end
      check($sformatf("frame%0d", b), {22'h0, frame}, {22'h0, 1'b1, exp_q[b], 1'b0});
      check($sformatf("stable%0d", b), {31'h0, stable}, 32'h1);
    end
    check("busy_during", {31'h0, busy_ok}, 32'h1);
    check("ready_back", {31'h0, req_ready}, 32'h1);
    check("busy_end", {31'h0, busy}, 32'h0);
    check("tx_idle", {31'h0, TX}, 32'h1);
  endtask

  task automatic idle_check(input int n);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (TX !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
      @(posedge CLK); #1;
    end
    check("stay_idle", {31'h0, ok}, 32'h1);
  endtask

  initial begin
    int t;
    logic [31:0] n;
    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx", {31'h0, TX}, 32'h1);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // PONG
    build_exp(0, 32'h0);
    start_req(0, 32'h0);
    recv_msg(0, 1'b0);

    // INFO
    build_exp(1, 32'h0);
    start_req(1, 32'h0);
    recv_msg(0, 1'b0);

    // NONCE, inputs scrambled right after acceptance
    build_exp(3, 32'h1DAC2B7C);
    start_req(3, 32'h1DAC2B7C);
    recv_msg(0, 1'b0);

    // Reserved type with a request pulse mid-message
    build_exp(6, 32'h0);
    start_req(6, 32'h0);
    recv_msg(200, 1'b0);
    idle_check(3 * BP);

    // Request held high across message end is taken at once
    build_exp(0, 32'h0);
    start_req(0, 32'h0);
    recv_msg(0, 1'b1);
    @(posedge CLK); #1;
    check("held_accept_busy", {31'h0, busy}, 32'h1);
    check("held_accept_tx", {31'h0, TX}, 32'h0);
    recv_msg(0, 1'b0);

    // Reset during the third INFO byte
    start_req(1, 32'h0);
    repeat ((2 * 10 + 3) * BP + 2 - 1) begin
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    check("pre_rst_tx", {31'h0, TX}, 32'h0);
    #2 RST = 1'b1;
    #1;
    check("midrst_tx", {31'h0, TX}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_ready", {31'h0, req_ready}, 32'h0);
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    check("rerst_ready", {31'h0, req_ready}, 32'h1);
    check("rerst_tx", {31'h0, TX}, 32'h1);
    build_exp(0, 32'h0);
    start_req(0, 32'h0);
    recv_msg(0, 1'b0);
    idle_check(2 * BP);

    // Random requests
    for (int r = 0; r < 6; r++) begin
      t = $urandom_range(0, 7);
      n = $urandom;
      build_exp(t, n);
      start_req(t, n);
      recv_msg((r % 2 == 1) ? $urandom_range(1, 150) : 0, 1'b0);
      repeat ($urandom_range(0, 5)) begin
        @(posedge CLK); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/resp_uart_tx.md
RESP_UART_TX -- requirements
Module: resp_uart_tx

Interface
REQ-001 SHALL have parameter baud_rate, default 1: UART bit rate in the units of sys_clk_freq.
REQ-002 SHALL have parameter sys_clk_freq, default 16: clock rate; bit period BP = sys_clk_freq/baud_rate cycles, integer and >= 2.
REQ-003 SHALL have port CLK  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  response request.
REQ-006 SHALL have port req_ready  output  1  high when a request can be accepted.
REQ-007 SHALL have port req_type  input  3  message: 0 PONG/ACK, 1 INFO, 2 INVALID, 3 NONCE, 4-7 reserved.
REQ-008 SHALL have port req_nonce  input  32  golden nonce for NONCE messages.
REQ-009 SHALL have port TX  output  1  UART serial line to the host, idle high.
REQ-010 SHALL have port busy  output  1  high from acceptance until the last stop bit ends.

Function
REQ-011 SHALL accept a request on a rising edge with req_valid && req_ready, latching req_type and req_nonce; later changes to these inputs SHALL NOT affect the message.
REQ-012 SHALL deassert req_ready and assert busy in the cycle after acceptance; req_ready SHALL return high in the cycle after the final stop bit's BP cycles end.
REQ-013 SHALL emit each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly BP cycles.
REQ-014 SHALL drive the first start bit in the cycle after acceptance, with the next byte's start bit immediately after the prior stop bit and no idle gap.
REQ-015 SHALL send PONG/ACK as 1 byte: 01.
REQ-016 SHALL send INFO as 16 bytes: 10 00 00 00 DE AD BE EF 13 37 0D 13 T0 T1 T2 T3.
REQ-017 SHALL send INVALID as 8 bytes: 08 00 00 01 T0 T1 T2 T3.
REQ-018 SHALL send NONCE as 8 bytes: 08 00 00 03 N[31:24] N[23:16] N[15:8] N[7:0].
REQ-019 SHALL treat reserved req_type 4-7 as INVALID.
REQ-020 SHALL define trailer bytes T0-T3 per REQ-030/REQ-031.
REQ-021 SHALL use FSM states IDLE -> START -> DATA (8 bits) -> STOP, then START if bytes remain, else IDLE.
REQ-022 SHALL use a baud counter of 0..BP-1 that reloads on each bit boundary, a 3-bit bit index, and a 4-bit byte index that wraps only via return to IDLE.
REQ-023 SHALL ignore req_valid while busy and SHALL NOT queue it.
REQ-024 SHALL accept a request held high at message end in the first cycle req_ready is high.

Reset
REQ-025 SHALL, while RST is high, force TX=1, req_ready=0, busy=0, state IDLE, and all counters and latched fields to 0.
REQ-026 SHALL, on RST deassertion, drive req_ready=1 on the first clock edge.
REQ-027 SHALL, on RST mid-message, drive TX high immediately (asynchronously) and discard the message with no resume.

Configuration
REQ-028 SHALL have macro RESP_CRC_EN select the trailer content.
REQ-029 SHALL affect only T0-T3 via RESP_CRC_EN, with byte counts and all other bytes unchanged.
REQ-030 SHALL, with RESP_CRC_EN undefined, send T0-T3 = 00 00 00 00 and include no CRC logic.
REQ-031 SHALL, with RESP_CRC_EN defined, send T0-T3 = CRC-32 over all preceding bytes of that message, least-significant byte first, computed bytewise while shifting and ready before T0.
REQ-032 SHALL use CRC-32 per IEEE 802.3: reflected poly EDB88320, init FFFFFFFF, final XOR FFFFFFFF.

Verification
REQ-033 SHALL test PONG with baud_rate=1, sys_clk_freq=16: req_type=0 -> TX emits 01, 160 cycles start-to-stop-end, req_ready back high next cycle.
REQ-034 SHALL test INFO with RESP_CRC_EN undefined: req_type=1 -> 10 00 00 00 DE AD BE EF 13 37 0D 13 00 00 00 00, back-to-back frames.
REQ-035 SHALL test NONCE: req_type=3, req_nonce=1DAC2B7C, then nonce changed next cycle -> 08 00 00 03 1D AC 2B 7C.
REQ-036 SHALL test reserved type and busy: req_type=6 -> 08 00 00 01 00 00 00 00; a pulse during transmission -> no extra message.
REQ-037 SHALL test reset mid-message: RST during the 3rd byte of INFO -> TX=1 same cycle; after release a PONG request -> clean single 01 byte.
REQ-038 SHALL test CRC trailer with RESP_CRC_EN defined: INVALID -> trailer equals a bench-computed CRC-32 of 08 00 00 01, LSB first.
